// File: rtl/ai_pkg.sv
// Shared opcodes, controller states and defaults for the AI move controller.
// Also provides the 5-bit signed column-difference helpers used to plan shifts.
package ai_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_ROT_CW = 3'd1,
    OP_LEFT   = 3'd2,
    OP_RIGHT  = 3'd3,
    OP_DROP   = 3'd4
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_COLLECT = 3'd2,
    ST_ROTATE  = 3'd3,
    ST_SHIFT   = 3'd4,
    ST_DROP    = 3'd5,
    ST_DONE    = 3'd6
  } ai_state_e;

  localparam logic [3:0] SPAWN_X_DEF = 4'd3;
  localparam logic [7:0] TIMEOUT_DEF = 8'd255;

  function automatic logic signed [4:0] shift_diff(input logic [3:0] x, input logic [3:0] spawn);
    return $signed({1'b0, x}) - $signed({1'b0, spawn});
  endfunction

  // Column distances never exceed 15, so the magnitude fits the 4-bit counter.
  function automatic logic [3:0] shift_mag(input logic signed [4:0] d);
    logic signed [4:0] a;
    a = d[4] ? -d : d;
    return a[3:0];
  endfunction

endpackage

// File: rtl/ai_best_tracker.sv
// Keeps the best candidate seen during collection and presents the placement
// that would be chosen if collection ended this cycle (fallback when none).
module ai_best_tracker
  import ai_pkg::*;
#(
  parameter logic [3:0] SPAWN_X = SPAWN_X_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_cand_valid,
  input  logic [1:0] i_cand_rot,
  input  logic [3:0] i_cand_x,
  input  logic [7:0] i_cand_score,
  output logic [1:0] o_sel_rot,
  output logic [3:0] o_sel_x
);

  logic [7:0] r_best_score;
  logic [1:0] r_best_rot;
  logic [3:0] r_best_x;
  logic       r_best_valid;
  logic       w_take;

  // Strict compare keeps the earlier candidate on a tie.
  assign w_take = i_en && i_cand_valid && (!r_best_valid || (i_cand_score > r_best_score));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_best_score <= 8'd0;
      r_best_rot   <= 2'd0;
      r_best_x     <= 4'd0;
      r_best_valid <= 1'b0;
    end else if (i_clr) begin
      r_best_valid <= 1'b0;
    end else if (w_take) begin
      r_best_score <= i_cand_score;
      r_best_rot   <= i_cand_rot;
      r_best_x     <= i_cand_x;
      r_best_valid <= 1'b1;
    end
  end

  always_comb begin
    o_sel_rot = 2'd0;
    o_sel_x   = SPAWN_X;
    if (w_take) begin
      o_sel_rot = i_cand_rot;
      o_sel_x   = i_cand_x;
    end else if (r_best_valid) begin
      o_sel_rot = r_best_rot;
      o_sel_x   = r_best_x;
    end
  end

endmodule

// File: rtl/ai_move_controller.sv
// AI move controller: collects engine candidates, then issues ROT_CW/LEFT/RIGHT/DROP
// commands over a valid/ready handshake. Define AI_TIMEOUT_EN to add the COLLECT watchdog.
//   state   | meaning
//   IDLE    | waiting for ai_go
//   START   | one-cycle engine start, best cleared
//   COLLECT | evaluating candidates until cand_last (or watchdog)
//   ROTATE  | issuing ROT_CW commands
//   SHIFT   | issuing LEFT/RIGHT commands
//   DROP    | issuing the single DROP command
//   DONE    | move_done pulse
module ai_move_controller
  import ai_pkg::*;
#(
  parameter logic [3:0] SPAWN_X     = SPAWN_X_DEF,
  parameter logic [7:0] TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ai_go,
  output logic       eng_start,
  input  logic       cand_valid,
  input  logic [1:0] cand_rot,
  input  logic [3:0] cand_x,
  input  logic [7:0] cand_score,
  input  logic       cand_last,
  output logic       cmd_valid,
  output logic [2:0] cmd_op,
  input  logic       cmd_ready,
  output logic       busy,
  output logic       move_done
);

`ifdef AI_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  ai_state_e r_state, w_nxt_state;
  logic [3:0] r_cnt, w_nxt_cnt;
  logic [3:0] r_shift, w_nxt_shift;
  logic       r_left, w_nxt_left;
  logic       r_cmd_valid, w_nxt_cmd_valid;
  cmd_op_e    r_cmd_op, w_nxt_cmd_op;
  logic [7:0] r_to;
  logic       w_timeout;
  logic       w_hs;
  logic       w_collect_end;
  logic [1:0] w_sel_rot;
  logic [3:0] w_sel_x;
  logic signed [4:0] w_diff;
  logic [3:0] w_dist;

  ai_best_tracker #(
    .SPAWN_X (SPAWN_X)
  ) u_best (
    .clk          (clk),
    .rst          (reset),
    .i_clr        (r_state == ST_START),
    .i_en         (r_state == ST_COLLECT),
    .i_cand_valid (cand_valid),
    .i_cand_rot   (cand_rot),
    .i_cand_x     (cand_x),
    .i_cand_score (cand_score),
    .o_sel_rot    (w_sel_rot),
    .o_sel_x      (w_sel_x)
  );

  assign w_hs          = r_cmd_valid && cmd_ready;
  assign w_diff        = shift_diff(w_sel_x, SPAWN_X);
  assign w_dist        = shift_mag(w_diff);
  assign w_timeout     = TO_EN && (r_state == ST_COLLECT) && !cand_valid &&
                         (r_to == TIMEOUT_CYC - 8'd1);
  assign w_collect_end = (cand_valid && cand_last) || w_timeout;

  // Watchdog counts idle COLLECT cycles; stays at zero when the feature is off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to <= 8'd0;
    end else if (!TO_EN || r_state != ST_COLLECT || cand_valid) begin
      r_to <= 8'd0;
    end else begin
      r_to <= r_to + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_shift     <= 4'd0;
      r_left      <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= OP_NOP;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_shift     <= w_nxt_shift;
      r_left      <= w_nxt_left;
      r_cmd_valid <= w_nxt_cmd_valid;
      r_cmd_op    <= w_nxt_cmd_op;
    end
  end

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_cnt       = r_cnt;
    w_nxt_shift     = r_shift;
    w_nxt_left      = r_left;
    w_nxt_cmd_valid = 1'b0;
    w_nxt_cmd_op    = OP_NOP;

    case (r_state)
      ST_IDLE: begin
        if (ai_go) w_nxt_state = ST_START;
      end
      ST_START: begin
        w_nxt_state = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (w_collect_end) begin
          w_nxt_shift = w_dist;
          w_nxt_left  = w_diff[4];
          if (w_sel_rot != 2'd0) begin
            w_nxt_state = ST_ROTATE;
            w_nxt_cnt   = {2'b00, w_sel_rot};
          end else if (w_dist != 4'd0) begin
            w_nxt_state = ST_SHIFT;
            w_nxt_cnt   = w_dist;
          end else begin
            w_nxt_state = ST_DROP;
            w_nxt_cnt   = 4'd0;
          end
        end
      end
      ST_ROTATE: begin
        if (w_hs && r_cnt != 4'd0) w_nxt_cnt = r_cnt - 4'd1;
        if (r_cnt == 4'd0 || (w_hs && r_cnt == 4'd1)) begin
          if (r_shift != 4'd0) begin
            w_nxt_state = ST_SHIFT;
            w_nxt_cnt   = r_shift;
          end else begin
            w_nxt_state = ST_DROP;
            w_nxt_cnt   = 4'd0;
          end
        end
      end
      ST_SHIFT: begin
        if (w_hs && r_cnt != 4'd0) w_nxt_cnt = r_cnt - 4'd1;
        if (r_cnt == 4'd0 || (w_hs && r_cnt == 4'd1)) begin
          w_nxt_state = ST_DROP;
          w_nxt_cnt   = 4'd0;
        end
      end
      ST_DROP: begin
        if (w_hs) w_nxt_state = ST_DONE;
      end
      ST_DONE: begin
        w_nxt_state = ST_IDLE;
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase

    // Command register is loaded from the upcoming state so it holds steady under stall.
    case (w_nxt_state)
      ST_ROTATE: begin
        if (w_nxt_cnt != 4'd0) begin
          w_nxt_cmd_valid = 1'b1;
          w_nxt_cmd_op    = OP_ROT_CW;
        end
      end
      ST_SHIFT: begin
        if (w_nxt_cnt != 4'd0) begin
          w_nxt_cmd_valid = 1'b1;
          w_nxt_cmd_op    = w_nxt_left ? OP_LEFT : OP_RIGHT;
        end
      end
      ST_DROP: begin
        w_nxt_cmd_valid = 1'b1;
        w_nxt_cmd_op    = OP_DROP;
      end
      default: begin
        w_nxt_cmd_valid = 1'b0;
        w_nxt_cmd_op    = OP_NOP;
      end
    endcase
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_op    = r_cmd_op;
  assign busy      = (r_state != ST_IDLE);
  assign eng_start = (r_state == ST_START);
  assign move_done = (r_state == ST_DONE);

endmodule

// File: doc/ai_move_controller.md
AI_MOVE_CONTROLLER -- requirements
Module: ai_move_controller

Interface
REQ-001 The block SHALL have parameter SPAWN_X, default 4'd3, the spawn column of the active piece.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 8'd255, the COLLECT watchdog limit in cycles.
REQ-003 The block SHALL have port clk  input  1  system clock.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset; one clock domain only.
REQ-005 The block SHALL have port ai_go  input  1  request one move for the current piece.
REQ-006 The block SHALL have port eng_start  output  1  start pulse to the placement engine.
REQ-007 The block SHALL have port cand_valid  input  1  candidate placement present this cycle.
REQ-008 The block SHALL have port cand_rot  input  2  candidate rotation count.
REQ-009 The block SHALL have port cand_x  input  4  candidate left column, 0..9.
REQ-010 The block SHALL have port cand_score  input  8  candidate score, unsigned, higher is better.
REQ-011 The block SHALL have port cand_last  input  1  final candidate; qualified by cand_valid.
REQ-012 The block SHALL have port cmd_valid  output  1  command available.
REQ-013 The block SHALL have port cmd_op  output  3  command: 0 NOP, 1 ROT_CW, 2 LEFT, 3 RIGHT, 4 DROP.
REQ-014 The block SHALL have port cmd_ready  input  1  game FSM accepts the command.
REQ-015 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 The block SHALL have port move_done  output  1  one-cycle pulse after DROP is accepted.

Function
REQ-017 The block SHALL use the states IDLE, START, COLLECT, ROTATE, SHIFT, DROP and DONE.
REQ-018 IDLE SHALL go to START when ai_go=1; ai_go SHALL be ignored in every other state.
REQ-019 START SHALL last exactly 1 cycle, SHALL drive eng_start=1, SHALL clear best_valid, and SHALL then go to COLLECT.
REQ-020 In COLLECT, a candidate with cand_valid=1 SHALL replace the best when best_valid=0 or cand_score > best_score.
REQ-021 On equal scores the earlier candidate SHALL be kept.
REQ-022 cand_valid and cand_last SHALL go to ROTATE on the next cycle; the candidate presented in that same cycle SHALL be evaluated.
REQ-023 In COLLECT, if cand_last arrives with no valid best, the block SHALL use the fallback move rot=0, x=SPAWN_X.
REQ-024 ROTATE SHALL issue ROT_CW best_rot times; when best_rot=0 the block SHALL go directly to SHIFT.
REQ-025 SHIFT SHALL issue |best_x - SPAWN_X| commands, LEFT if best_x < SPAWN_X and RIGHT otherwise; when the distance is 0 the block SHALL go directly to DROP.
REQ-026 The shift difference SHALL be computed at 5-bit signed width.
REQ-027 DROP SHALL issue one DROP command and SHALL then go to DONE.
REQ-028 DONE SHALL pulse move_done for 1 cycle and SHALL return to IDLE.
REQ-029 cmd_valid SHALL be registered.
REQ-030 cmd_op SHALL remain stable while cmd_valid=1 and cmd_ready=0.
REQ-031 A command SHALL be consumed only when cmd_valid=1 and cmd_ready=1 in the same cycle.
REQ-032 The remaining-command counter SHALL be 4 bits, SHALL decrement only on handshake, and SHALL never underflow.
REQ-033 cmd_op SHALL equal NOP whenever cmd_valid=0.
REQ-034 Inputs cand_rot, cand_x and cand_score SHALL be treated as don't-care when cand_valid=0.

Reset
REQ-035 Reset asserted SHALL force state IDLE, clear best_valid, and zero every counter.
REQ-036 Reset asserted SHALL force eng_start=0, cmd_valid=0, cmd_op=NOP, busy=0 and move_done=0.
REQ-037 Reset asserted mid-move SHALL abort the move immediately with no further command issued.
REQ-038 The first ai_go after reset deassertion SHALL be honoured.

Configuration
REQ-039 With AI_TIMEOUT_EN defined, a cycle counter SHALL run in COLLECT and SHALL clear on every cand_valid.
REQ-040 With AI_TIMEOUT_EN defined, on reaching TIMEOUT_CYC the block SHALL proceed to ROTATE with the best so far, or the fallback when none exists.
REQ-041 Without AI_TIMEOUT_EN, the block SHALL remain in COLLECT until cand_last arrives.

Structure
REQ-042 Package ai_pkg SHALL hold the command opcode enum, the controller state enum, and the SPAWN_X default constant.
REQ-043 Sub-module ai_best_tracker SHALL hold the best_score, best_rot, best_x and best_valid registers and the compare logic.

Verification
REQ-044 The bench SHALL cover: candidates (r0,x0,s10), (r1,x5,s40), (r2,x7,s40,last) -> the best is r1/x5 -> commands ROT_CW, RIGHT, RIGHT, DROP, then move_done.
REQ-045 The bench SHALL cover: a single candidate (r0,x3,s1,last) -> a single DROP only, with move_done 1 cycle after acceptance.
REQ-046 The bench SHALL cover: best x=0 with cmd_ready held low 5 cycles -> cmd_op=LEFT stable throughout, and exactly 3 LEFT commands accepted in total.
REQ-047 The bench SHALL cover: cand_last with cand_valid=1 and score 255 on the final cycle -> that candidate is selected.
REQ-048 The bench SHALL cover: reset pulse during SHIFT -> cmd_valid=0 and busy=0 on the next edge, and no DROP issued.
REQ-049 The bench SHALL cover: AI_TIMEOUT_EN defined with no candidates -> after 255 cycles the block issues DROP only (fallback) and pulses move_done.
